// File: rtl/floo_axis_flit_serializer.sv
// Splits each InWidth-bit AXIS word into NumBeats OutWidth-bit beats, LSB slice first,
// and zero-pads the top of the final beat. The next word can load on the final beat.
module floo_axis_flit_serializer #(
  parameter int unsigned InWidth  = 80,
  parameter int unsigned OutWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [InWidth-1:0]  in_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [OutWidth-1:0] out_data_o,
  output logic                out_last_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam int unsigned NumBeatsRaw = (InWidth + OutWidth - 1) / OutWidth;
  localparam int unsigned NumBeats    = (NumBeatsRaw < 1) ? 1 : NumBeatsRaw;
  localparam int unsigned CntW        = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam int unsigned PadW        = NumBeats * OutWidth;
  localparam logic [CntW-1:0] LastCnt = CntW'(NumBeats - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e              state_p0;
  logic [InWidth-1:0]  word_p0;
  logic [CntW-1:0]     cnt_p0;
  logic [PadW-1:0]     word_pad;
  logic                vld_p0;
  logic                last_beat;
  logic                in_fire;
  logic                out_fire;

  assign vld_p0    = (state_p0 == SEND);
  assign last_beat = vld_p0 && (cnt_p0 == LastCnt);
  assign in_ready_o  = (state_p0 == IDLE) || (last_beat && out_ready_i);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_fire    = vld_p0 && out_ready_i;
  assign out_valid_o = vld_p0;
  assign out_last_o  = last_beat;
  assign word_pad    = PadW'(word_p0);

  // Stage p0 -> output: select the current slice of the held word
  always_comb begin
    out_data_o = '0;
    for (int unsigned k = 0; k < NumBeats; k++) begin
      if (vld_p0 && (cnt_p0 == CntW'(k))) begin
        out_data_o = word_pad[k*OutWidth +: OutWidth];
      end
    end
  end

  // Stage input -> p0: word capture and beat sequencing
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      word_p0  <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (in_fire) begin
            word_p0  <= in_data_i;
            cnt_p0   <= '0;
            state_p0 <= SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (last_beat) begin
              cnt_p0 <= '0;
              if (in_fire) begin
                word_p0  <= in_data_i;
                state_p0 <= SEND;
              end else begin
                state_p0 <= IDLE;
              end
            end else begin
              cnt_p0 <= cnt_p0 + 1'b1;
            end
          end
        end
        default: begin
          state_p0 <= IDLE;
          cnt_p0   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_floo_axis_flit_serializer.sv
// Directed and random checks for the flit serializer: a 40->16 instance (3 beats)
// and a 40->48 instance (single beat).
module tb_floo_axis_flit_serializer;

  logic        clk;
  logic        rst;
  logic [39:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  logic [39:0] in1_data;
  logic        in1_valid;
  logic        in1_ready;
  logic [47:0] out1_data;
  logic        out1_last;
  logic        out1_valid;
  logic        out1_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic        sb_en = 1'b0;
  logic [39:0] in_q[$];
  logic [47:0] acc;
  int          beat_idx;
  int          n_acc;
  int          n_last;

  floo_axis_flit_serializer #(.InWidth(40), .OutWidth(16)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready)
  );

  floo_axis_flit_serializer #(.InWidth(40), .OutWidth(48)) dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_data_i  (in1_data),
    .in_valid_i (in1_valid),
    .in_ready_o (in1_ready),
    .out_data_o (out1_data),
    .out_last_o (out1_last),
    .out_valid_o(out1_valid),
    .out_ready_i(out1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d, input logic l);
    @(negedge clk);
    check({tag, "_vld"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(d));
    check({tag, "_last"}, 64'(out_last), 64'(l));
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    check({tag, "_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_rdy"}, 64'(in_ready), 64'd1);
  endtask

  // Scoreboard: reassemble beats into words and compare with accepted inputs
  always @(negedge clk) begin
    if (sb_en) begin
      if (in_valid && in_ready) begin
        in_q.push_back(in_data);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        acc = acc | (48'(out_data) << (beat_idx * 16));
        beat_idx++;
        if (out_last) begin
          n_last++;
          check("rnd_beats", 64'(beat_idx), 64'd3);
          if (in_q.size() == 0) begin
            check("rnd_underflow", 64'(acc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            check("rnd_word", 64'(acc), 64'(in_q.pop_front()));
          end
          acc      = '0;
          beat_idx = 0;
        end
      end
    end
  end

  initial begin
    logic [63:0] r;
    int cyc;
    rst        = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    in1_data   = '0;
    in1_valid  = 1'b0;
    out1_ready = 1'b1;
    acc        = '0;
    beat_idx   = 0;
    n_acc      = 0;
    n_last     = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst1_vld", 64'(out1_valid), 64'd0);
    check("rst1_data", 64'(out1_data), 64'd0);
    check("rst1_rdy", 64'(in1_ready), 64'd1);
    tick();

    // Single word
    in_data  = 40'h12_3456_789A;
    in_valid = 1'b1;
    @(negedge clk);
    check("t1_in_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 40'hDE_ADBE_EF00;
    chk_beat("t1_b0", 16'h789A, 1'b0); tick();
    chk_beat("t1_b1", 16'h3456, 1'b0); tick();
    chk_beat("t1_b2", 16'h0012, 1'b1); tick();
    chk_idle("t1_end");
    tick();

    // Back-to-back words with no bubble
    in_data  = 40'h00_0000_0001;
    in_valid = 1'b1;
    tick();
    in_data  = 40'hFF_FFFF_FFFF;
    chk_beat("t2_b0", 16'h0001, 1'b0);
    check("t2_b0_rdy", 64'(in_ready), 64'd0);
    tick();
    chk_beat("t2_b1", 16'h0000, 1'b0);
    check("t2_b1_rdy", 64'(in_ready), 64'd0);
    tick();
    chk_beat("t2_b2", 16'h0000, 1'b1);
    check("t2_b2_rdy", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk_beat("t2_b3", 16'hFFFF, 1'b0); tick();
    chk_beat("t2_b4", 16'hFFFF, 1'b0); tick();
    chk_beat("t2_b5", 16'h00FF, 1'b1); tick();
    chk_idle("t2_end");
    tick();

    // Backpressure during beat 1
    in_data  = 40'h12_3456_789A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_beat("t3_b0", 16'h789A, 1'b0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 40'hAA_AAAA_AAAA;
    for (int i = 0; i < 4; i++) begin
      chk_beat("t3_stall", 16'h3456, 1'b0);
      check("t3_stall_rdy", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk_beat("t3_b1", 16'h3456, 1'b0); tick();
    chk_beat("t3_b2", 16'h0012, 1'b1); tick();
    chk_idle("t3_end");
    tick();

    // Reset mid-word discards remaining beats
    in_data  = 40'h12_3456_789A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk_beat("t4_b0", 16'h789A, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_rst_data", 64'(out_data), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk_idle("t4_after");
      tick();
    end

    // Single-beat instance: zero extension, full throughput
    in1_data  = 40'hAB_CDEF_0123;
    in1_valid = 1'b1;
    tick();
    in1_data = 40'h11_1111_1111;
    @(negedge clk);
    check("t5_b0_vld", 64'(out1_valid), 64'd1);
    check("t5_b0_data", 64'(out1_data), 64'h0000_ABCD_EF01_23);
    check("t5_b0_last", 64'(out1_last), 64'd1);
    check("t5_b0_rdy", 64'(in1_ready), 64'd1);
    tick();
    in1_valid = 1'b0;
    @(negedge clk);
    check("t5_b1_vld", 64'(out1_valid), 64'd1);
    check("t5_b1_data", 64'(out1_data), 64'h0000_1111_1111_11);
    check("t5_b1_last", 64'(out1_last), 64'd1);
    tick();
    @(negedge clk);
    check("t5_end_vld", 64'(out1_valid), 64'd0);
    tick();

    // Random valid/ready with scoreboard
    sb_en = 1'b1;
    cyc   = 0;
    while (n_acc < 1000 && cyc < 30000) begin
      r         = {$urandom, $urandom};
      in_data   = r[39:0];
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && out_valid; i++) tick();
    tick();
    sb_en = 1'b0;
    check("rnd_count", 64'(n_acc), 64'd1000);
    check("rnd_lasts", 64'(n_last), 64'(n_acc));
    check("rnd_q_empty", 64'(in_q.size()), 64'd0);
    check("rnd_idle", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
